data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the M stage: captures one load/store,
// waits LATENCY cycles, then pulses a one-cycle response with extended load data.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memrq,
  input  logic        memwq,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        access_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW+1:0]   c_addr;
  logic [31:0]     c_wdata;
  logic [2:0]      c_f3;
  logic            c_rd;
  logic            c_wr;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [31:0]     shifted;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     load_val;
  logic [3:0]      lanes;
  logic [31:0]     wbus;
  logic            err;
  logic            mis;
  logic            commit;
  logic            unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr = ^addr[31:AW+2];

  assign stall = !rst && ((state == IDLE && (memrq || memwq)) || state == WAIT);

  always_comb begin
    idx      = c_addr[AW+1:2];
    word     = mem[idx];
    shifted  = word >> {c_addr[1:0], 3'b000};
    sel_byte = shifted[7:0];
    sel_half = c_addr[1] ? word[31:16] : word[15:0];

    load_val = '0;
    case (c_f3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = '0;
    endcase

    err = c_rd && c_wr;
    if (c_wr && !(c_f3 inside {3'b000, 3'b001, 3'b010}))
      err = 1'b1;
    if (c_rd && !(c_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      err = 1'b1;

    mis = (c_f3[1:0] == 2'b01 && c_addr[0]) ||
          (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);

    lanes = '0;
    wbus  = c_wdata;
    case (c_f3[1:0])
      2'b00: begin
        lanes = 4'b0001 << c_addr[1:0];
        wbus  = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        lanes = c_addr[1] ? 4'b1100 : 4'b0011;
        wbus  = {2{c_wdata[15:0]}};
      end
      2'b10:   lanes = 4'b1111;
      default: lanes = '0;
    endcase

    commit = (state == WAIT) && (cnt == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      c_addr     <= '0;
      c_wdata    <= '0;
      c_f3       <= '0;
      c_rd       <= 1'b0;
      c_wr       <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
      access_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memrq || memwq) begin
            c_addr  <= addr[AW+1:0];
            c_wdata <= wdata;
            c_f3    <= funct3;
            c_rd    <= memrq;
            c_wr    <= memwq;
            cnt     <= CNT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            misalign   <= mis;
            access_err <= err;
            rdata      <= (c_rd && !c_wr && !err && !mis) ? load_val : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          rdata      <= '0;
          misalign   <= 1'b0;
          access_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store data lands on the same edge that enters DONE; rst gates a coincident edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_wr && !c_rd && !err && !mis) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i])
          mem[idx][i*8 +: 8] <= wbus[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memrq;
  logic        memwq;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        access_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .memrq(memrq), .memwq(memwq), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid),
    .rdata(rdata), .misalign(misalign), .access_err(access_err)
  );

  typedef struct {
    string       name;
    logic        rq;
    logic        wq;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memrq = 1'b0; memwq = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int  stalls = 0;
    bit  seen = 0;
    bit  quiet = 1;
    logic [31:0] got_rdata = '0;
    logic got_mis = 1'b0;
    logic got_err = 1'b0;
    @(negedge clk);
    memrq = v.rq; memwq = v.wq; funct3 = v.f3; addr = v.a; wdata = v.wd;
    #1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (resp_valid) begin
        seen = 1;
        got_rdata = rdata; got_mis = misalign; got_err = access_err;
      end else begin
        if (stall) stalls++;
        if (rdata !== '0 || misalign !== 1'b0 || access_err !== 1'b0) quiet = 0;
        @(negedge clk); #1;
      end
    end
    idle_inputs();
    vectors++;
    check({v.name, " resp_seen"}, 32'(seen), 32'd1);
    check({v.name, " stall_cycles"}, 32'(stalls), 32'(LAT + 1));
    check({v.name, " quiet_before_done"}, 32'(quiet), 32'd1);
    check({v.name, " rdata"}, got_rdata, v.exp_rdata);
    check({v.name, " misalign"}, 32'(got_mis), 32'(v.exp_mis));
    check({v.name, " access_err"}, 32'(got_err), 32'(v.exp_err));
    @(posedge clk); #1;
    check({v.name, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic add(input string n, input logic rq, input logic wq, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                     input logic em, input logic ee);
    vec_t v;
    v.name = n; v.rq = rq; v.wq = wq; v.f3 = f3; v.a = a; v.wd = wd;
    v.exp_rdata = er; v.exp_mis = em; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    //  name          rq wq f3      addr          wdata         rdata         mis  err
    add("sw_10",      0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0);
    add("lw_10",      1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 0);
    add("sb_13",      0, 1, 3'b000, 32'h13,  32'h00000080, 32'h0,        0, 0);
    add("lb_13",      1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0, 0);
    add("lbu_13",     1, 0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0, 0);
    add("lw_10_sb",   1, 0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0, 0);
    add("lh_11_mis",  1, 0, 3'b001, 32'h11,  32'h0,        32'h0,        1, 0);
    add("sw_12_mis",  0, 1, 3'b010, 32'h12,  32'h55555555, 32'h0,        1, 0);
    add("both_rqwq",  1, 1, 3'b010, 32'h10,  32'h0,        32'h0,        0, 1);
    add("both_mis",   1, 1, 3'b010, 32'h11,  32'h0,        32'h0,        1, 1);
    add("sw_f3_011",  0, 1, 3'b011, 32'h10,  32'h0,        32'h0,        0, 1);
    add("lw_10_kept", 1, 0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0, 0);
    add("lhu_12",     1, 0, 3'b101, 32'h12,  32'h0,        32'h000080AD, 0, 0);
    add("lh_12",      1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFF80AD, 0, 0);
    add("lbu_10",     1, 0, 3'b100, 32'h10,  32'h0,        32'h000000EF, 0, 0);
    add("lb_11",      1, 0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 0, 0);
    add("sh_16",      0, 1, 3'b001, 32'h16,  32'hAAAA1234, 32'h0,        0, 0);
    add("lhu_16",     1, 0, 3'b101, 32'h16,  32'h0,        32'h00001234, 0, 0);
    add("sw_400",     0, 1, 3'b010, 32'h400, 32'h12345678, 32'h0,        0, 0);
    add("lw_0_alias", 1, 0, 3'b010, 32'h0,   32'h0,        32'h12345678, 0, 0);
    add("sw_20",      0, 1, 3'b010, 32'h20,  32'h11111111, 32'h0,        0, 0);

    // Reset state, with a request pending at the input
    idle_inputs();
    memrq = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    check("reset stall", 32'(stall), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset flags", {30'd0, misalign, access_err}, 32'd0);
    memrq = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second WAIT cycle discards the store
    @(negedge clk);
    memwq = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk);              // IDLE -> WAIT
    @(posedge clk);              // second WAIT cycle
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    vectors++;
    check("rst_wait stall", 32'(stall), 32'd0);
    check("rst_wait resp_valid", 32'(resp_valid), 32'd0);
    check("rst_wait rdata", rdata, 32'd0);
    begin
      bit pulse = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (resp_valid || stall) pulse = 1;
      end
      check("rst_wait no_response", 32'(pulse), 32'd0);
    end
    begin
      vec_t v;
      v.name = "lw_20_after_rst"; v.rq = 1; v.wq = 0; v.f3 = 3'b010; v.a = 32'h20;
      v.wd = '0; v.exp_rdata = 32'h11111111; v.exp_mis = 0; v.exp_err = 0;
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
